// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared encodings and widths for the AES pair scheduler
package aes_sched_pkg;
  localparam int AES_BLK_W = 128;
  localparam int PAIR_W    = 256;

  typedef enum logic [1:0] {
    PAIR_FREE  = 2'd0,
    PAIR_BUSY  = 2'd1,
    PAIR_READY = 2'd2
  } pair_state_t;

  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_KEY   = 2'd2
  } sched_fsm_t;
endpackage

// File: rtl/aes_pair_slot.sv
// rtl/aes_pair_slot.sv - one core pair: state, lane completion flags and result register
module aes_pair_slot
  import aes_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              retire,
  input  logic [1:0]        done,
  input  logic [PAIR_W-1:0] res_in,
  output logic [1:0]        state,
  output logic [PAIR_W-1:0] res,
  output logic              spur
);
  pair_state_t st;
  logic [1:0]  flags;

  assign state = st;
  assign spur  = (|done) && (st != PAIR_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= PAIR_FREE;
      flags <= 2'b00;
      res   <= '0;
    end else begin
      case (st)
        PAIR_FREE: if (ld) st <= PAIR_BUSY;
        PAIR_BUSY: begin
          for (int l = 0; l < 2; l++)
            if (done[l]) res[l*AES_BLK_W +: AES_BLK_W] <= res_in[l*AES_BLK_W +: AES_BLK_W];
          // Second lane in (either order, or both together) completes the pair.
          if ((flags | done) == 2'b11) begin
            st    <= PAIR_READY;
            flags <= 2'b00;
          end else begin
            flags <= flags | done;
          end
        end
        PAIR_READY: if (retire) st <= PAIR_FREE;
        default: st <= PAIR_FREE;
      endcase
    end
  end
endmodule

// File: rtl/aes_pair_scheduler.sv
// rtl/aes_pair_scheduler.sv - round-robin dispatch/retire over paired AES cores with drained key change
// Optional perf_blocks/perf_stall counters under AES_PAIR_SCHED_PERF_EN.
module aes_pair_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_PAIRS = 12,
  parameter int PTR_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PAIR_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PAIR_W-1:0]           out_data,
  input  logic                        key_wr,
  input  logic [AES_BLK_W-1:0]        key_in,
  output logic                        key_busy,
  output logic [AES_BLK_W-1:0]        core_key,
  output logic [PAIR_W-1:0]           core_text,
  output logic [NUM_PAIRS-1:0]        core_ld,
  input  logic [2*NUM_PAIRS-1:0]      core_done,
  input  logic [PAIR_W*NUM_PAIRS-1:0] core_res,
`ifdef AES_PAIR_SCHED_PERF_EN
  output logic [31:0]                 perf_blocks,
  output logic [31:0]                 perf_stall,
`endif
  output logic                        err_spur
);
  logic [1:0]           slot_state [NUM_PAIRS];
  logic [PAIR_W-1:0]    slot_res   [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] slot_spur, slot_free, accept_vec, retire_vec;
  logic [PTR_W-1:0]     issue_ptr, ret_ptr;
  logic [AES_BLK_W-1:0] key_pend;
  sched_fsm_t           fsm;
  logic                 accept, retire;

  assign in_ready  = (fsm == FSM_RUN) && slot_free[issue_ptr];
  assign out_valid = (slot_state[ret_ptr] == PAIR_READY);
  assign out_data  = slot_res[ret_ptr];
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    assign slot_free[p]  = (slot_state[p] == PAIR_FREE);
    assign accept_vec[p] = accept && (issue_ptr == PTR_W'(p));
    assign retire_vec[p] = retire && (ret_ptr == PTR_W'(p));

    aes_pair_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .ld     (accept_vec[p]),
      .retire (retire_vec[p]),
      .done   (core_done[2*p +: 2]),
      .res_in (core_res[PAIR_W*p +: PAIR_W]),
      .state  (slot_state[p]),
      .res    (slot_res[p]),
      .spur   (slot_spur[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_ptr <= '0;
      ret_ptr   <= '0;
      core_ld   <= '0;
      core_text <= '0;
      core_key  <= '0;
      key_pend  <= '0;
      key_busy  <= 1'b0;
      err_spur  <= 1'b0;
      fsm       <= FSM_RUN;
    end else begin
      core_ld <= accept_vec;
      if (accept) begin
        core_text <= in_data;
        issue_ptr <= (issue_ptr == PTR_W'(NUM_PAIRS-1)) ? '0 : issue_ptr + PTR_W'(1);
      end
      if (retire)
        ret_ptr <= (ret_ptr == PTR_W'(NUM_PAIRS-1)) ? '0 : ret_ptr + PTR_W'(1);
      if (|slot_spur) err_spur <= 1'b1;

      // An accept coinciding with key_wr still dispatches; the drain then waits for it.
      case (fsm)
        FSM_RUN: if (key_wr) begin
          key_pend <= key_in;
          key_busy <= 1'b1;
          fsm      <= FSM_DRAIN;
        end
        FSM_DRAIN: if (&slot_free) fsm <= FSM_KEY;
        FSM_KEY: begin
          core_key <= key_pend;
          key_busy <= 1'b0;
          fsm      <= FSM_RUN;
        end
        default: fsm <= FSM_RUN;
      endcase
    end
  end

`ifdef AES_PAIR_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (retire) perf_blocks <= perf_blocks + 32'd1;
      if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_aes_pair_scheduler.sv
// tb/tb_aes_pair_scheduler.sv - directed and random checks of aes_pair_scheduler against a queue-based model
module tb_aes_pair_scheduler;
  localparam int NP = 12;
  localparam int NL = 2 * NP;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [255:0]    in_data, out_data, core_text;
  logic            key_wr, key_busy, err_spur;
  logic [127:0]    key_in, core_key;
  logic [NP-1:0]   core_ld;
  logic [NL-1:0]   core_done;
  logic [256*NP-1:0] core_res;
`ifdef AES_PAIR_SCHED_PERF_EN
  logic [31:0]     perf_blocks, perf_stall;
`endif

  always #5 clk = ~clk;

  aes_pair_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key_wr    (key_wr),
    .key_in    (key_in),
    .key_busy  (key_busy),
    .core_key  (core_key),
    .core_text (core_text),
    .core_ld   (core_ld),
    .core_done (core_done),
    .core_res  (core_res),
`ifdef AES_PAIR_SCHED_PERF_EN
    .perf_blocks (perf_blocks),
    .perf_stall  (perf_stall),
`endif
    .err_spur  (err_spur)
  );

  int total = 0;
  int bad = 0;
  logic [255:0] sb[$];
  int ptr_model, pending, n_acc, n_ret, key_chg, last_pair;
  int cnt [NL];
  int lat [NL];
  logic [127:0] val [NL];
  logic [127:0] key_model, prev_key;
  logic [255:0] last_ret, hold_d;
  bit use_rand, rand_out, hold_v;

  // Stand-in for an AES core: the known-answer vector, otherwise a key/text mix.
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && t == P0) return C0;
    return {t[62:0], t[127:63]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc, ret;
    logic [255:0] acc_d;
    logic [NP-1:0] ld_exp;
    int acc_p;
    acc   = in_valid && in_ready;
    ret   = out_valid && out_ready;
    acc_d = in_data;
    acc_p = ptr_model;
    if (acc) sb.push_back({fake_aes(key_model, in_data[255:128]), fake_aes(key_model, in_data[127:0])});
    if (ret) begin
      chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) chk("out_data", out_data, sb.pop_front());
      last_ret = out_data;
      n_ret++;
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    @(posedge clk);
    #1;
    key_wr    = 1'b0;
    core_done = '0;
    if (hold_v) begin
      chk("out_valid_hold", 256'(out_valid), 256'(1));
      chk("out_data_hold", out_data, hold_d);
    end
    ld_exp = '0;
    if (acc) ld_exp[acc_p] = 1'b1;
    chk("core_ld", 256'(core_ld), 256'(ld_exp));
    if (acc) begin
      chk("core_text", core_text, acc_d);
      ptr_model = (ptr_model + 1) % NP;
      n_acc++;
      pending--;
      if (pending > 0) in_data = rand256();
      else in_valid = 1'b0;
    end
    if (core_key !== prev_key) key_chg++;
    prev_key = core_key;
    for (int l = 0; l < NL; l++) begin
      if (cnt[l] > 0) begin
        cnt[l]--;
        if (cnt[l] == 0) begin
          core_done[l] = 1'b1;
          core_res[l*128 +: 128] = val[l];
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (core_ld[p]) begin
        last_pair = p;
        for (int h = 0; h < 2; h++) begin
          cnt[2*p+h] = use_rand ? int'($urandom_range(1, 6)) : lat[2*p+h];
          val[2*p+h] = fake_aes(core_key, core_text[h*128 +: 128]);
        end
      end
    end
    if (rand_out) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_wait();
    for (int i = 0; i < 200 && pending > 0; i++) tick();
    chk("send_done", 256'(pending == 0), 256'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 1000 && (sb.size() != 0 || pending > 0); i++) tick();
    chk("drained", 256'(sb.size() == 0 && pending == 0), 256'(1));
    tick();
  endtask

  task automatic send_one();
    pending  = 1;
    in_valid = 1'b1;
    in_data  = rand256();
    drain();
  endtask

  initial begin
    int a0, r0, p0;
    bit lo_prev, hi_seen, seen_ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    key_wr = 1'b0; key_in = '0; core_done = '0; core_res = '0;
    ptr_model = 0; pending = 0; n_acc = 0; n_ret = 0; key_chg = 0; last_pair = -1;
    key_model = '0; prev_key = '0; last_ret = '0; hold_d = '0; hold_v = 0;
    use_rand = 1; rand_out = 0;
    for (int l = 0; l < NL; l++) begin cnt[l] = 0; lat[l] = 2; val[l] = '0; end

    #3;
    chk("rst_core_ld", 256'(core_ld), 256'(0));
    chk("rst_core_text", core_text, 256'(0));
    chk("rst_core_key", 256'(core_key), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_key_busy", 256'(key_busy), 256'(0));
    chk("rst_err_spur", 256'(err_spur), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 256'(in_ready), 256'(1));

    // 13 blocks with the consumer stalled: 12 fill the bank, the 13th waits for pair 0.
    a0 = n_acc;
    pending = 13; in_valid = 1'b1; in_data = rand256();
    for (int i = 0; i < 25; i++) tick();
    chk("fill_accepts", 256'(n_acc - a0), 256'(12));
    chk("fill_in_ready", 256'(in_ready), 256'(0));
    chk("fill_out_valid", 256'(out_valid), 256'(1));
    out_ready = 1'b1;
    r0 = n_ret;
    for (int i = 0; i < 12; i++) tick();
    chk("burst_returns", 256'(n_ret - r0), 256'(12));
    chk("thirteenth_pair", 256'(last_pair), 256'(0));
    chk("thirteenth_sent", 256'(pending), 256'(0));
    drain();

    // Known-answer vector under K0.
    key_wr = 1'b1; key_in = K0;
    tick();
    key_model = K0;
    chk("kat_key_busy", 256'(key_busy), 256'(1));
    for (int i = 0; i < 20 && key_busy; i++) tick();
    chk("kat_key_idle", 256'(key_busy), 256'(0));
    chk("kat_core_key", 256'(core_key), 256'(K0));
    use_rand = 0;
    pending = 1; in_valid = 1'b1; in_data = {P0, P0};
    drain();
    chk("kat_out", last_ret, {C0, C0});

    // Pair 3 with hi finishing three cycles before lo.
    while (ptr_model != 3) send_one();
    lat[6] = 6; lat[7] = 3;
    out_ready = 1'b0;
    pending = 1; in_valid = 1'b1; in_data = rand256();
    lo_prev = 0; hi_seen = 0; seen_ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (lo_prev) begin
        chk("skew_out_valid", 256'(out_valid), 256'(1));
        seen_ok = 1;
        break;
      end
      chk("skew_wait", 256'(out_valid), 256'(0));
      if (core_done[7]) hi_seen = 1;
      if (core_done[6]) begin
        chk("skew_hi_first", 256'(hi_seen), 256'(1));
        lo_prev = 1;
      end
    end
    chk("skew_seen", 256'(seen_ok), 256'(1));
    drain();
    lat[6] = 2; lat[7] = 2;
    use_rand = 1;

    // Key change with three blocks in flight; the third accept coincides with key_wr.
    out_ready = 1'b0;
    pending = 2; in_valid = 1'b1; in_data = rand256();
    send_wait();
    chk("kc_in_ready", 256'(in_ready), 256'(1));
    pending = 2; in_valid = 1'b1; in_data = rand256();
    key_wr = 1'b1; key_in = K1;
    tick();
    key_model = K1;
    key_chg = 0;
    chk("kc_third_sent", 256'(pending), 256'(1));
    for (int i = 0; i < 8; i++) begin
      chk("kc_busy", 256'(key_busy), 256'(1));
      chk("kc_in_ready_low", 256'(in_ready), 256'(0));
      if (i == 3) begin key_wr = 1'b1; key_in = K2; end
      tick();
    end
    drain();
    chk("kc_changes", 256'(key_chg), 256'(1));
    chk("kc_core_key", 256'(core_key), 256'(K1));
    chk("kc_idle", 256'(key_busy), 256'(0));

    // Random traffic with random backpressure and lane skew.
    rand_out = 1;
    pending = 150; in_valid = 1'b1; in_data = rand256();
    for (int i = 0; i < 3000 && (pending > 0 || sb.size() != 0); i++) tick();
    rand_out = 0;
    drain();

    // Spurious done on lane 4 (pair 2, free).
    chk("spur_before", 256'(err_spur), 256'(0));
    p0 = ptr_model;
    core_done[4] = 1'b1;
    tick();
    chk("spur_set", 256'(err_spur), 256'(1));
    chk("spur_out_valid", 256'(out_valid), 256'(0));
    chk("spur_in_ready", 256'(in_ready), 256'(1));
    send_one();
    chk("spur_pair", 256'(last_pair), 256'(p0));
    chk("spur_sticky", 256'(err_spur), 256'(1));

    // Asynchronous reset with five pairs busy.
    use_rand = 0;
    for (int l = 0; l < NL; l++) lat[l] = 40;
    out_ready = 1'b0;
    pending = 5; in_valid = 1'b1; in_data = rand256();
    send_wait();
    tick();
    chk("busy5_out_valid", 256'(out_valid), 256'(0));
    rst = 1'b1;
    #1;
    chk("arst_core_ld", 256'(core_ld), 256'(0));
    chk("arst_core_text", core_text, 256'(0));
    chk("arst_core_key", 256'(core_key), 256'(0));
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_out_data", out_data, 256'(0));
    chk("arst_err_spur", 256'(err_spur), 256'(0));
    chk("arst_key_busy", 256'(key_busy), 256'(0));
    sb.delete();
    ptr_model = 0; key_model = '0; pending = 0; in_valid = 1'b0;
    core_done = '0;
    for (int l = 0; l < NL; l++) begin cnt[l] = 0; lat[l] = 2; end
    tick();
    rst = 1'b0;
    chk("rel_in_ready", 256'(in_ready), 256'(1));
    send_one();
    chk("rel_pair", 256'(last_pair), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_pair_scheduler.md
Name: aes_pair_scheduler

Overview:
- Front-end scheduler for the bank of paired aes_cipher_top cores. A pair is two cores sharing one load strobe; one core gets text[127:0], the other gets text[255:128].
- Accepts 256-bit plaintext blocks over valid/ready and dispatches each to a free pair round-robin.
- Captures both halves of the result on the core done pulses and returns ciphertext in issue order over valid/ready.
- Owns the shared key bus; a key change first drains all in-flight pairs.

Parameters:
- NUM_PAIRS, 12, number of core pairs driven; pair p = lanes 2p (lo) and 2p+1 (hi).
- PTR_W, 4, pointer width; must satisfy 2**PTR_W >= NUM_PAIRS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  block accepted when in_valid&&in_ready.
- in_data  in  256  plaintext; [127:0] goes to the lo lane.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer ready.
- out_data  out  256  ciphertext; [127:0] comes from the lo lane.
- key_wr  in  1  one-cycle new-key request.
- key_in  in  128  new key, sampled with key_wr.
- key_busy  out  1  key change in progress.
- core_key  out  128  shared key to all cores.
- core_text  out  256  shared plaintext to all pairs.
- core_ld  out  NUM_PAIRS  per-pair load strobe.
- core_done  in  2*NUM_PAIRS  per-lane done pulses.
- core_res  in  256*NUM_PAIRS  lane results; pair p occupies [256p+255:256p].
- err_spur  out  1  sticky: done seen on a pair that was not BUSY.

Behaviour:
- Reset (async): all outputs 0; issue_ptr=ret_ptr=0; all pairs FREE; FSM=RUN; result registers 0.
- Per-pair state: FREE -> BUSY on dispatch; BUSY -> READY when both lane flags are set; READY -> FREE on retire.
- in_ready = (FSM==RUN) && pair[issue_ptr]==FREE. It is registered-state based, with no combinational path from in_valid.
- Accept at cycle t:
  - core_text<=in_data.
  - core_ld[issue_ptr]=1 for exactly cycle t+1; all other ld bits 0.
  - issue_ptr wraps NUM_PAIRS-1 -> 0.
  - core_text holds until the next accept.
- Done capture, lane l of pair p BUSY:
  - core_done[l] loads core_res lane l into res[p] and sets flag[l].
  - Lo and hi may arrive in any order or in the same cycle.
  - The pair becomes READY the cycle after its second flag is set; flags clear at the same time.
  - A done on a FREE or READY pair is ignored and sets err_spur, which clears only on reset.
- Retire:
  - out_valid = pair[ret_ptr]==READY; out_data = res[ret_ptr].
  - On out_valid&&out_ready: pair->FREE, ret_ptr++ with wrap.
  - out_data is stable while out_valid && !out_ready.
- Ordering: strict round-robin issue and retire, so output order equals input order regardless of lane completion skew.
- Latency: accept t; ld t+1; done at t+1+Lcore; out_valid at done+1 at the earliest.
- All pairs BUSY/READY: in_ready=0 until ret_ptr's pair retires.
- Key FSM:
  - RUN: key_wr latches key_pend and moves to DRAIN. key_wr is ignored while key_busy=1.
  - DRAIN: in_ready=0; retire continues; go to KEY when all pairs are FREE. Same cycle if already idle.
  - KEY: core_key<=key_pend; next state RUN.
  - key_busy=1 in DRAIN and KEY.
  - key_wr in the same cycle as an accept: the accept completes with the old key, then DRAIN.

Optional Feature:
- Macro AES_PAIR_SCHED_PERF_EN.
- Defined: adds outputs perf_blocks[31:0] (increments per retire) and perf_stall[31:0] (increments each cycle in_valid&&!in_ready). Both counters wrap and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package aes_sched_pkg:
  - pair-state encoding (FREE=2'd0, BUSY=2'd1, READY=2'd2);
  - FSM encoding (RUN, DRAIN, KEY);
  - AES_BLK_W=128, PAIR_W=256.
- One natural sub-module, aes_pair_slot: per-pair state, lane flags, and result register. It is instantiated NUM_PAIRS times. Pointers and the key FSM stay in the top.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f; in_data = 00112233445566778899aabbccddeeff in both halves -> out_data = 69c4e0d86a7b0430d8cdb78070b4c55a in both halves; core_ld[0] high exactly one cycle after accept.
- 13 back-to-back blocks with out_ready=0 -> 12 accepted, then in_ready=0. Raise out_ready -> 12 outputs in input order on consecutive cycles, then the 13th block is accepted into pair 0.
- Pair 3: hi done 3 cycles before lo -> out_valid only after lo done+1; out_data halves correctly placed.
- key_wr with 3 blocks in flight -> key_busy=1 and in_ready=0 until 3 retire; core_key updates once; the next block encrypts under the new key.
- core_done[4] pulse while pair 2 is FREE -> err_spur=1; pair states and pointers unchanged.
- rst pulsed with 5 pairs BUSY -> outputs 0 immediately; after release in_ready=1, issue_ptr=0, and the next block retires correctly.
